core_select_sequencer: RTL and testbench
========================================

Name: core_select_sequencer

Overview:
- Generalised successor to the fixed 4-way CPU-core output selector in the emu top level.
- Selects one of NUM_CORES microcomputer cores and muxes its video, SD-SPI, UART and LED outputs to the top level.
- Sequences every core change safely: SD bus released, all cores held in reset, video blanked until the new core's first VSync.
- Each core gets a clock enable instead of a gated clock.

Parameters:
- NUM_CORES, 4, number of selectable cores; 2..16.
- SEL_W, 4, width of the select bus; must satisfy 2**SEL_W >= NUM_CORES.
- DRAIN_CYCLES, 64, cycles SD CS is forced high before the cores are reset.
- RESET_CYCLES, 1024, cycles all cores are held in reset.
- SYNC_TIMEOUT, 2000000, maximum cycles to wait for the new core's VSync before unblanking anyway.

Ports:
- clk  in  1  system clock (clk_sys).
- N_RESET  in  1  asynchronous active-low reset.
- sel_req  in  SEL_W  requested core index, from OSD status.
- ext_reset  in  1  synchronous active-high user/OSD reset request.
- core_r, core_g, core_b  in  2*NUM_CORES each  per-core 2-bit colour; core i occupies bits [2i+1:2i].
- core_hs, core_vs, core_hblank, core_vblank, core_cepix  in  NUM_CORES each  per-core sync, blank and pixel enable.
- core_sdcs, core_sdmosi, core_sdsck, core_led, core_txd  in  NUM_CORES each  per-core SD-SPI, active-low drive LED, UART TX.
- core_nreset  out  NUM_CORES  per-core active-low reset.
- core_en  out  NUM_CORES  per-core clock enable; one-hot.
- r, g, b  out  2 each  selected colour.
- hs, vs, hblank, vblank, cepix  out  1 each  selected video timing.
- sd_cs, sd_mosi, sd_sck, drive_led, txd  out  1 each  selected peripheral outputs.
- active_sel  out  SEL_W  index of the core currently driving the outputs.
- switching  out  1  high whenever state != RUN.

Behaviour:
- All outputs are registered; the mux path has 1-cycle latency from core inputs to outputs.
- Reset values:
  - state = RESET, active_sel = 0, target = 0, counter = 0.
  - core_nreset all 0; core_en = one-hot bit 0.
  - Idle pattern: r/g/b = 0, hs = vs = 0, hblank = vblank = 1, cepix = 0, sd_cs = 1, sd_mosi = 0, sd_sck = 0, drive_led = 1, txd = 1.
- Valid request: sel_req < NUM_CORES. Invalid requests are ignored, with no state change.
- RUN:
  - Outputs follow core active_sel; core_nreset[active_sel] = 1, all others 0.
  - A valid sel_req != active_sel latches target, clears the counter and moves to DRAIN.
  - ext_reset moves to RESET with target = active_sel.
- DRAIN:
  - Video still comes from the old core.
  - sd_cs = 1, sd_sck = 0, sd_mosi = 0, txd = 1, overriding the old core.
  - After DRAIN_CYCLES cycles, moves to RESET.
- RESET:
  - All core_nreset = 0; outputs hold the idle pattern.
  - On entry, active_sel and core_en switch to target.
  - After RESET_CYCLES cycles, moves to WAIT_SYNC.
- WAIT_SYNC:
  - core_nreset[active_sel] = 1.
  - Video is idle-blanked, but cepix is forwarded from the new core.
  - SD, UART and LED outputs are forwarded from the new core.
  - Moves to RUN on the first rising edge of core_vs[active_sel] (registered edge detect), or when the counter reaches SYNC_TIMEOUT.
- A valid sel_req != target in DRAIN, RESET or WAIT_SYNC re-latches target and re-enters DRAIN (RESET and WAIT_SYNC) or restarts the DRAIN count.
- ext_reset in any non-RUN state restarts RESET with the current target. ext_reset has priority over sel_req in the same cycle.
- Counter: a single unsigned counter, width $clog2 of the maximum of the three cycle parameters plus 1. It saturates and never wraps.
- Asserting N_RESET mid-operation returns to the reset values immediately; the sequence restarts at RESET with target 0.

Decomposition:
- Package core_sel_pkg holds:
  - the state typedef (RUN, DRAIN, RESET, WAIT_SYNC);
  - the idle-pattern localparams;
  - a function extracting 2-bit slice i from the colour buses.
- Sub-module core_out_mux: registered NUM_CORES-to-1 mux of the video, SD, UART and LED bundles, with force_idle_video and force_idle_periph controls.
- The FSM and counter stay in the top-level module.

Test Plan:
- Power-up with sel_req = 0, core 0 toggling vs every 1000 cycles:
  - Expect core_nreset[0] low for 1024 cycles, then high.
  - Video unblanks on the first vs rise; switching falls in the same cycle.
- In RUN on core 0, set sel_req = 2 with core 0 driving sd_cs = 0:
  - Expect sd_cs = 1 for 64 cycles while video stays from core 0.
  - Then all core_nreset = 0, active_sel = 2, core_en = 4'b0100, RESET for 1024 cycles.
- During RESET, change sel_req 2 -> 3:
  - Expect re-entry to DRAIN and a full RESET, finishing with active_sel = 3.
  - No output ever reflects core 2 in RUN.
- New core never produces vs:
  - Expect WAIT_SYNC to exit after exactly SYNC_TIMEOUT cycles (use 100 in the bench) and RUN with video unblanked.
- sel_req = 7 with NUM_CORES = 4 in RUN:
  - Expect no state change, switching stays 0, active_sel unchanged.
- ext_reset and sel_req change in the same RUN cycle:
  - Expect RESET with target = old active_sel.
  - Assert N_RESET low mid-DRAIN: expect the reset values of every output within the same cycle.

Source files
------------

// File: rtl/core_sel_pkg.sv
// core_sel_pkg: shared types, idle levels and helpers
// for the core select sequencer.
package core_sel_pkg;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    RESET,
    WAIT_SYNC
  } state_t;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
    logic       hs;
    logic       vs;
    logic       hblank;
    logic       vblank;
    logic       cepix;
  } vid_t;

  typedef struct packed {
    logic sd_cs;
    logic sd_mosi;
    logic sd_sck;
    logic drive_led;
    logic txd;
  } per_t;

  localparam logic [1:0] IDLE_RGB    = 2'b00;
  localparam logic       IDLE_HS     = 1'b0;
  localparam logic       IDLE_VS     = 1'b0;
  localparam logic       IDLE_HBLANK = 1'b1;
  localparam logic       IDLE_VBLANK = 1'b1;
  localparam logic       IDLE_CEPIX  = 1'b0;
  localparam logic       IDLE_SDCS   = 1'b1;
  localparam logic       IDLE_SDMOSI = 1'b0;
  localparam logic       IDLE_SDSCK  = 1'b0;
  localparam logic       IDLE_LED    = 1'b1;
  localparam logic       IDLE_TXD    = 1'b1;

  localparam vid_t VID_IDLE = '{
    r:      IDLE_RGB,
    g:      IDLE_RGB,
    b:      IDLE_RGB,
    hs:     IDLE_HS,
    vs:     IDLE_VS,
    hblank: IDLE_HBLANK,
    vblank: IDLE_VBLANK,
    cepix:  IDLE_CEPIX
  };

  localparam per_t PER_IDLE = '{
    sd_cs:     IDLE_SDCS,
    sd_mosi:   IDLE_SDMOSI,
    sd_sck:    IDLE_SDSCK,
    drive_led: IDLE_LED,
    txd:       IDLE_TXD
  };

  function automatic logic [1:0] col_slice(
    input logic [31:0] bus,
    input logic [3:0]  i
  );
    return bus[{i, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/core_out_mux.sv
// core_out_mux: registered N-to-1 mux of per-core video,
// SD, UART and LED bundles with idle overrides.
module core_out_mux
  import core_sel_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int SEL_W     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   force_idle_video,
  input  logic                   force_idle_periph,
  input  logic [2*NUM_CORES-1:0] core_r,
  input  logic [2*NUM_CORES-1:0] core_g,
  input  logic [2*NUM_CORES-1:0] core_b,
  input  logic [NUM_CORES-1:0]   core_hs,
  input  logic [NUM_CORES-1:0]   core_vs,
  input  logic [NUM_CORES-1:0]   core_hblank,
  input  logic [NUM_CORES-1:0]   core_vblank,
  input  logic [NUM_CORES-1:0]   core_cepix,
  input  logic [NUM_CORES-1:0]   core_sdcs,
  input  logic [NUM_CORES-1:0]   core_sdmosi,
  input  logic [NUM_CORES-1:0]   core_sdsck,
  input  logic [NUM_CORES-1:0]   core_led,
  input  logic [NUM_CORES-1:0]   core_txd,
  output vid_t                   vid,
  output per_t                   per
);

  localparam int IW =
    (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [IW-1:0] idx;
  logic          all_idle;
  vid_t          vid_d;
  per_t          per_d;

  assign idx      = IW'(sel);
  assign all_idle = force_idle_video & force_idle_periph;

  always_comb begin
    vid_d.r      = col_slice(32'(core_r), 4'(idx));
    vid_d.g      = col_slice(32'(core_g), 4'(idx));
    vid_d.b      = col_slice(32'(core_b), 4'(idx));
    vid_d.hs     = core_hs[idx];
    vid_d.vs     = core_vs[idx];
    vid_d.hblank = core_hblank[idx];
    vid_d.vblank = core_vblank[idx];
    vid_d.cepix  = core_cepix[idx];
    per_d.sd_cs     = core_sdcs[idx];
    per_d.sd_mosi   = core_sdmosi[idx];
    per_d.sd_sck    = core_sdsck[idx];
    per_d.drive_led = core_led[idx];
    per_d.txd       = core_txd[idx];
    // cepix and LED only go idle when both bundles are forced
    if (force_idle_video) begin
      vid_d.r      = VID_IDLE.r;
      vid_d.g      = VID_IDLE.g;
      vid_d.b      = VID_IDLE.b;
      vid_d.hs     = VID_IDLE.hs;
      vid_d.vs     = VID_IDLE.vs;
      vid_d.hblank = VID_IDLE.hblank;
      vid_d.vblank = VID_IDLE.vblank;
    end
    if (force_idle_periph) begin
      per_d.sd_cs   = PER_IDLE.sd_cs;
      per_d.sd_mosi = PER_IDLE.sd_mosi;
      per_d.sd_sck  = PER_IDLE.sd_sck;
      per_d.txd     = PER_IDLE.txd;
    end
    if (all_idle) begin
      vid_d.cepix     = VID_IDLE.cepix;
      per_d.drive_led = PER_IDLE.drive_led;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vid <= VID_IDLE;
      per <= PER_IDLE;
    end else begin
      vid <= vid_d;
      per <= per_d;
    end
  end

endmodule

// File: rtl/core_select_sequencer.sv
// core_select_sequencer: picks one core, muxes its outputs
// and sequences drain / reset / resync on every change.
module core_select_sequencer
  import core_sel_pkg::*;
#(
  parameter int NUM_CORES    = 4,
  parameter int SEL_W        = 4,
  parameter int DRAIN_CYCLES = 64,
  parameter int RESET_CYCLES = 1024,
  parameter int SYNC_TIMEOUT = 2000000
) (
  input  logic                   clk,
  input  logic                   N_RESET,
  input  logic [SEL_W-1:0]       sel_req,
  input  logic                   ext_reset,
  input  logic [2*NUM_CORES-1:0] core_r,
  input  logic [2*NUM_CORES-1:0] core_g,
  input  logic [2*NUM_CORES-1:0] core_b,
  input  logic [NUM_CORES-1:0]   core_hs,
  input  logic [NUM_CORES-1:0]   core_vs,
  input  logic [NUM_CORES-1:0]   core_hblank,
  input  logic [NUM_CORES-1:0]   core_vblank,
  input  logic [NUM_CORES-1:0]   core_cepix,
  input  logic [NUM_CORES-1:0]   core_sdcs,
  input  logic [NUM_CORES-1:0]   core_sdmosi,
  input  logic [NUM_CORES-1:0]   core_sdsck,
  input  logic [NUM_CORES-1:0]   core_led,
  input  logic [NUM_CORES-1:0]   core_txd,
  output logic [NUM_CORES-1:0]   core_nreset,
  output logic [NUM_CORES-1:0]   core_en,
  output logic [1:0]             r,
  output logic [1:0]             g,
  output logic [1:0]             b,
  output logic                   hs,
  output logic                   vs,
  output logic                   hblank,
  output logic                   vblank,
  output logic                   cepix,
  output logic                   sd_cs,
  output logic                   sd_mosi,
  output logic                   sd_sck,
  output logic                   drive_led,
  output logic                   txd,
  output logic [SEL_W-1:0]       active_sel,
  output logic                   switching
);

  localparam int MAX_DR =
    (DRAIN_CYCLES > RESET_CYCLES) ? DRAIN_CYCLES : RESET_CYCLES;
  localparam int MAX_C =
    (MAX_DR > SYNC_TIMEOUT) ? MAX_DR : SYNC_TIMEOUT;
  localparam int CW = $clog2(MAX_C) + 1;
  localparam int IW =
    (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] RESET_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] SYNC_LAST  = CW'(SYNC_TIMEOUT - 1);

  state_t               state;
  state_t               state_nxt;
  logic [SEL_W-1:0]     target;
  logic [SEL_W-1:0]     target_nxt;
  logic [SEL_W-1:0]     active_sel_nxt;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_nxt;
  logic [CW-1:0]        cnt_inc;
  logic                 vs_q;
  logic                 vs_cur;
  logic                 vs_rise;
  logic                 req_valid;
  logic                 req_new;
  logic [NUM_CORES-1:0] nreset_nxt;
  logic [NUM_CORES-1:0] en_nxt;
  logic                 switching_nxt;
  logic                 idle_video;
  logic                 idle_periph;
  vid_t                 vid;
  per_t                 per;

  assign vs_cur    = core_vs[IW'(active_sel)];
  assign vs_rise   = vs_cur & ~vs_q;
  assign cnt_inc   = (&cnt) ? cnt : cnt + 1'b1;
  assign req_valid =
    {1'b0, sel_req} < (SEL_W + 1)'(NUM_CORES);
  // target always equals active_sel while running
  assign req_new   = req_valid && (sel_req != target);

  always_ff @(posedge clk or negedge N_RESET) begin
    if (!N_RESET) begin
      state       <= RESET;
      target      <= '0;
      active_sel  <= '0;
      cnt         <= '0;
      vs_q        <= 1'b0;
      core_nreset <= '0;
      core_en     <= NUM_CORES'(1);
      switching   <= 1'b1;
    end else begin
      state       <= state_nxt;
      target      <= target_nxt;
      active_sel  <= active_sel_nxt;
      cnt         <= cnt_nxt;
      vs_q        <= vs_cur;
      core_nreset <= nreset_nxt;
      core_en     <= en_nxt;
      switching   <= switching_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    cnt_nxt    = cnt_inc;
    if (ext_reset) begin
      state_nxt = RESET;
      cnt_nxt   = '0;
      if (state == RUN) target_nxt = active_sel;
    end else if (req_new) begin
      state_nxt  = DRAIN;
      target_nxt = sel_req;
      cnt_nxt    = '0;
    end else begin
      case (state)
        DRAIN: if (cnt == DRAIN_LAST) begin
          state_nxt = RESET;
          cnt_nxt   = '0;
        end
        RESET: if (cnt == RESET_LAST) begin
          state_nxt = WAIT_SYNC;
          cnt_nxt   = '0;
        end
        WAIT_SYNC: if (vs_rise || cnt == SYNC_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
        end
        default: cnt_nxt = '0;
      endcase
    end
    active_sel_nxt =
      (state_nxt == RESET) ? target_nxt : active_sel;
  end

  // decoded from next state so outputs align with state
  always_comb begin
    en_nxt        = NUM_CORES'(1) << IW'(active_sel_nxt);
    nreset_nxt    = (state_nxt == RESET) ? '0 : en_nxt;
    switching_nxt = (state_nxt != RUN);
    idle_video    = (state_nxt == RESET) ||
                    (state_nxt == WAIT_SYNC);
    idle_periph   = (state_nxt == RESET) ||
                    (state_nxt == DRAIN);
  end

  core_out_mux #(
    .NUM_CORES (NUM_CORES),
    .SEL_W     (SEL_W)
  ) u_mux (
    .clk               (clk),
    .rst_n             (N_RESET),
    .sel               (active_sel_nxt),
    .force_idle_video  (idle_video),
    .force_idle_periph (idle_periph),
    .core_r            (core_r),
    .core_g            (core_g),
    .core_b            (core_b),
    .core_hs           (core_hs),
    .core_vs           (core_vs),
    .core_hblank       (core_hblank),
    .core_vblank       (core_vblank),
    .core_cepix        (core_cepix),
    .core_sdcs         (core_sdcs),
    .core_sdmosi       (core_sdmosi),
    .core_sdsck        (core_sdsck),
    .core_led          (core_led),
    .core_txd          (core_txd),
    .vid               (vid),
    .per               (per)
  );

  assign r         = vid.r;
  assign g         = vid.g;
  assign b         = vid.b;
  assign hs        = vid.hs;
  assign vs        = vid.vs;
  assign hblank    = vid.hblank;
  assign vblank    = vid.vblank;
  assign cepix     = vid.cepix;
  assign sd_cs     = per.sd_cs;
  assign sd_mosi   = per.sd_mosi;
  assign sd_sck    = per.sd_sck;
  assign drive_led = per.drive_led;
  assign txd       = per.txd;

endmodule

// File: tb/tb_core_select_sequencer.sv
// tb_core_select_sequencer: random stimulus against a
// phase/remaining-cycles model of the selector.
module tb_core_select_sequencer;

  localparam int NC = 4;
  localparam int SW = 4;
  localparam int DC = 64;
  localparam int RC = 1024;
  localparam int ST = 100;

  localparam int P_RUN   = 0;
  localparam int P_DRAIN = 1;
  localparam int P_RESET = 2;
  localparam int P_WAIT  = 3;

  logic          clk = 1'b0;
  logic          N_RESET = 1'b1;
  logic [SW-1:0] sel_req = '0;
  logic          ext_reset = 1'b0;
  logic [2*NC-1:0] core_r, core_g, core_b;
  logic [NC-1:0] core_hs, core_vs, core_hblank, core_vblank;
  logic [NC-1:0] core_cepix, core_sdcs, core_sdmosi;
  logic [NC-1:0] core_sdsck, core_led, core_txd;
  logic [NC-1:0] core_nreset, core_en;
  logic [1:0]    r, g, b;
  logic          hs, vs, hblank, vblank, cepix;
  logic          sd_cs, sd_mosi, sd_sck, drive_led, txd;
  logic [SW-1:0] active_sel;
  logic          switching;

  always #5 clk = ~clk;

  core_select_sequencer #(
    .NUM_CORES    (NC),
    .SEL_W        (SW),
    .DRAIN_CYCLES (DC),
    .RESET_CYCLES (RC),
    .SYNC_TIMEOUT (ST)
  ) dut (
    .clk (clk), .N_RESET (N_RESET),
    .sel_req (sel_req), .ext_reset (ext_reset),
    .core_r (core_r), .core_g (core_g), .core_b (core_b),
    .core_hs (core_hs), .core_vs (core_vs),
    .core_hblank (core_hblank), .core_vblank (core_vblank),
    .core_cepix (core_cepix), .core_sdcs (core_sdcs),
    .core_sdmosi (core_sdmosi), .core_sdsck (core_sdsck),
    .core_led (core_led), .core_txd (core_txd),
    .core_nreset (core_nreset), .core_en (core_en),
    .r (r), .g (g), .b (b), .hs (hs), .vs (vs),
    .hblank (hblank), .vblank (vblank), .cepix (cepix),
    .sd_cs (sd_cs), .sd_mosi (sd_mosi), .sd_sck (sd_sck),
    .drive_led (drive_led), .txd (txd),
    .active_sel (active_sel), .switching (switching)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int vs_per [NC];
  bit hold_cs0 = 1'b0;

  int m_ph, m_left, m_act, m_tgt;
  bit m_vsp;
  logic [12:0] e_ctrl;
  logic [10:0] e_vid;
  logic [4:0]  e_per;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0d: got %h expected %h",
               tag, cyc, got, exp);
    end
  endtask

  function automatic int dur(input int p);
    case (p)
      P_DRAIN: return DC;
      P_RESET: return RC;
      P_WAIT:  return ST;
      default: return 0;
    endcase
  endfunction

  task automatic m_enter(input int p);
    m_ph   = p;
    m_left = dur(p);
    if (p == P_RESET) m_act = m_tgt;
  endtask

  // expected outputs from the phase just entered and the
  // core inputs that were present at the clock edge
  task automatic m_outs();
    int a;
    logic [10:0] fwd;
    logic [4:0]  pf;
    a   = m_act;
    fwd = {core_r[2*a +: 2], core_g[2*a +: 2],
           core_b[2*a +: 2], core_hs[a], core_vs[a],
           core_hblank[a], core_vblank[a], core_cepix[a]};
    pf  = {core_sdcs[a], core_sdmosi[a], core_sdsck[a],
           core_led[a], core_txd[a]};
    case (m_ph)
      P_RUN:   begin e_vid = fwd; e_per = pf; end
      P_DRAIN: begin
        e_vid = fwd;
        e_per = {3'b100, core_led[a], 1'b1};
      end
      P_RESET: begin e_vid = 11'h006; e_per = 5'b10011; end
      default: begin
        e_vid = {10'h003, core_cepix[a]};
        e_per = pf;
      end
    endcase
    e_ctrl = {m_ph != P_RUN, 4'(m_act),
              (m_ph == P_RESET) ? 4'b0000 : 4'(1 << m_act),
              4'(1 << m_act)};
  endtask

  task automatic m_reset();
    m_ph = P_RESET; m_left = RC;
    m_act = 0; m_tgt = 0; m_vsp = 1'b0;
    m_outs();
  endtask

  task automatic m_step();
    bit vs_now, rise, valid;
    int cur;
    vs_now = core_vs[m_act];
    rise   = vs_now && !m_vsp;
    m_vsp  = vs_now;
    valid  = (int'(sel_req) < NC);
    cur    = (m_ph == P_RUN) ? m_act : m_tgt;
    if (ext_reset) begin
      if (m_ph == P_RUN) m_tgt = m_act;
      m_enter(P_RESET);
    end else if (valid && int'(sel_req) != cur) begin
      m_tgt = int'(sel_req);
      m_enter(P_DRAIN);
    end else if (m_ph != P_RUN) begin
      m_left--;
      if (m_ph == P_WAIT && rise) m_enter(P_RUN);
      else if (m_left == 0)
        m_enter(m_ph == P_DRAIN ? P_RESET :
                m_ph == P_RESET ? P_WAIT : P_RUN);
    end
    m_outs();
  endtask

  task automatic drive();
    core_r      = (2*NC)'($urandom);
    core_g      = (2*NC)'($urandom);
    core_b      = (2*NC)'($urandom);
    core_hs     = NC'($urandom);
    core_hblank = NC'($urandom);
    core_vblank = NC'($urandom);
    core_cepix  = NC'($urandom);
    core_sdcs   = NC'($urandom);
    core_sdmosi = NC'($urandom);
    core_sdsck  = NC'($urandom);
    core_led    = NC'($urandom);
    core_txd    = NC'($urandom);
    if (hold_cs0) core_sdcs[0] = 1'b0;
    for (int i = 0; i < NC; i++)
      core_vs[i] = (vs_per[i] != 0) &&
                   ((cyc % vs_per[i]) < vs_per[i] / 2);
  endtask

  task automatic check_all();
    chk("ctrl", 32'({switching, active_sel,
                     core_nreset, core_en}), 32'(e_ctrl));
    chk("video", 32'({r, g, b, hs, vs, hblank, vblank,
                      cepix}), 32'(e_vid));
    chk("periph", 32'({sd_cs, sd_mosi, sd_sck, drive_led,
                       txd}), 32'(e_per));
  endtask

  task automatic cycle();
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_all();
    cyc++;
    drive();
  endtask

  initial begin
    int n, n_low, n_dr, n_wt, n_sw;
    bit saw2;
    vs_per[0] = 64; vs_per[1] = 60;
    vs_per[2] = 300; vs_per[3] = 0;
    drive();
    #1 N_RESET = 1'b0;
    #1 m_reset();
    check_all();
    @(negedge clk) N_RESET = 1'b1;

    // power-up on core 0
    n = 0; n_low = 0;
    while (m_ph != P_RUN && n < 5000) begin
      if (core_nreset[0] == 1'b0) n_low++;
      cycle(); n++;
    end
    chk("pu_done", 32'(switching), 0);
    chk("pu_vs_unblank", 32'(vs), 1);
    chk("pu_nrst_low", n_low, RC);

    // switch 0 -> 2 while core 0 holds SD CS low
    repeat (20) cycle();
    hold_cs0 = 1'b1;
    sel_req = 4'd2;
    n = 0; n_dr = 0;
    do begin
      cycle(); n++;
      if (switching && active_sel == 0 && sd_cs) n_dr++;
    end while (m_ph != P_RESET && n < 300);
    hold_cs0 = 1'b0;
    chk("drain_len", n_dr, DC);
    chk("rst_act", 32'(active_sel), 2);
    chk("rst_en", 32'(core_en), 32'h4);
    chk("rst_nrst", 32'(core_nreset), 0);

    // retarget to core 3 during reset; core 3 never syncs
    repeat (100) cycle();
    sel_req = 4'd3;
    n = 0; n_wt = 0; saw2 = 1'b0;
    while (m_ph != P_RUN && n < 4000) begin
      cycle(); n++;
      if (switching && core_nreset == 4'b1000) n_wt++;
      if (!switching && active_sel == 2) saw2 = 1'b1;
    end
    chk("to_done", 32'(switching), 0);
    chk("to_wait_len", n_wt, ST);
    chk("to_act", 32'(active_sel), 3);
    chk("no_core2_run", 32'(saw2), 0);

    // out-of-range request is ignored
    sel_req = 4'd7;
    n_sw = 0;
    repeat (50) begin
      cycle();
      if (switching) n_sw++;
    end
    chk("inv_switch", n_sw, 0);
    chk("inv_act", 32'(active_sel), 3);

    // ext_reset beats a simultaneous request
    ext_reset = 1'b1; sel_req = 4'd1;
    cycle();
    ext_reset = 1'b0; sel_req = 4'd3;
    chk("xr_act", 32'(active_sel), 3);
    chk("xr_nrst", 32'(core_nreset), 0);
    n = 0;
    while (m_ph != P_RUN && n < 4000) begin
      cycle(); n++;
    end
    chk("xr_done", 32'(switching), 0);

    // N_RESET mid-drain
    sel_req = 4'd0;
    repeat (10) cycle();
    #2 N_RESET = 1'b0;
    #1 m_reset();
    check_all();
    sel_req = 4'd0;
    @(negedge clk) N_RESET = 1'b1;

    // random soak
    for (int k = 0; k < 9000; k++) begin
      if (k % 2000 == 0)
        for (int i = 0; i < NC; i++)
          case ($urandom_range(0, 3))
            0: vs_per[i] = 0;
            1: vs_per[i] = 40;
            2: vs_per[i] = 150;
            default: vs_per[i] = 700;
          endcase
      if ($urandom_range(0, 299) == 0)
        sel_req = SW'($urandom_range(0, 5));
      ext_reset = ($urandom_range(0, 799) == 0);
      cycle();
    end
    ext_reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
